// File: rtl/leaf_run_loader_pkg.sv
// Shared definitions for the leaf run loader: default geometry, FSM encoding and a
// constant-foldable clog2 used for counter and index widths.
package leaf_run_loader_pkg;

  localparam int LRL_LEAF_CNT   = 16;
  localparam int LRL_DATA_WIDTH = 32;
  localparam int LRL_LEN_SEQ    = 128;
  localparam int LRL_TERM_CNT   = 20;
  localparam int LRL_ADDR_WIDTH = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/leaf_run_loader_if.sv
// Memory-read and leaf-FIFO-write bus between the loader (master) and the
// record memory plus leaf FIFOs (slave).
interface leaf_run_loader_if
  import leaf_run_loader_pkg::*;
#(
  parameter int LEAF_CNT   = LRL_LEAF_CNT,
  parameter int DATA_WIDTH = LRL_DATA_WIDTH,
  parameter int ADDR_WIDTH = LRL_ADDR_WIDTH
) ();

  logic                  o_mem_rd;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] i_mem_data;
  logic [LEAF_CNT-1:0]   i_fifo_full;
  logic [LEAF_CNT-1:0]   o_fifo_write;
  logic [DATA_WIDTH-1:0] o_fifo_item;

  modport master (
    output o_mem_rd, o_mem_addr, o_fifo_write, o_fifo_item,
    input  i_mem_data, i_fifo_full
  );

  modport slave (
    input  o_mem_rd, o_mem_addr, o_fifo_write, o_fifo_item,
    output i_mem_data, i_fifo_full
  );

endinterface

// File: rtl/leaf_run_loader_rr_arbiter.sv
// Rotating-priority arbiter: grants the first request at or after the pointer and,
// when told to advance, moves the pointer to just past the winner.
module rr_arbiter
  import leaf_run_loader_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_adv,
  output logic [N-1:0]  o_grant_oh,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_any
);

  logic [IW-1:0] r_ptr;

  always_comb begin
    o_any       = 1'b0;
    o_grant_idx = '0;
    o_grant_oh  = '0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && i_req[IW'((int'(r_ptr) + k) % N)]) begin
        o_any       = 1'b1;
        o_grant_idx = IW'((int'(r_ptr) + k) % N);
      end
    end
    if (o_any) o_grant_oh[o_grant_idx] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_adv && o_any) begin
      r_ptr <= (o_grant_idx == IW'(N - 1)) ? '0 : o_grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/leaf_run_loader.sv
// Streams LEAF_CNT pre-sorted runs from record memory into the leaf FIFOs, one record
// per cycle round-robin, and appends TERM_CNT zero terminators to each run.
module leaf_run_loader
  import leaf_run_loader_pkg::*;
#(
  parameter int LEAF_CNT   = LRL_LEAF_CNT,
  parameter int DATA_WIDTH = LRL_DATA_WIDTH,
  parameter int LEN_SEQ    = LRL_LEN_SEQ,
  parameter int TERM_CNT   = LRL_TERM_CNT,
  parameter int ADDR_WIDTH = LRL_ADDR_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  leaf_run_loader_if.master bus
);

  localparam int TOTAL = LEN_SEQ + TERM_CNT;
  localparam int CW    = clog2(TOTAL + 1);
  localparam int IW    = (LEAF_CNT > 1) ? clog2(LEAF_CNT) : 1;
  localparam int SH    = clog2(LEN_SEQ);

  state_e                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt [LEAF_CNT];
  logic                  r_pend_vld, r_pend_term;
  logic [IW-1:0]         r_pend_idx;
  logic [LEAF_CNT-1:0]   w_fin, w_fin_nxt, w_req, w_grant_oh;
  logic [IW-1:0]         w_grant_idx;
  logic                  w_any, w_is_data, w_clear, w_rd;
  logic [DATA_WIDTH-1:0] w_item;

  // The pending leaf is excluded so its full flag already accounts for every write.
  always_comb begin
    w_fin = '0;
    w_req = '0;
    for (int i = 0; i < LEAF_CNT; i++) begin
      w_fin[i] = (r_cnt[i] == CW'(TOTAL));
      w_req[i] = (r_state == ST_RUN) && !w_fin[i] && !bus.i_fifo_full[i] &&
                 !(r_pend_vld && (r_pend_idx == IW'(i)));
    end
  end

  rr_arbiter #(.N(LEAF_CNT)) u_arb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (w_req),
    .i_adv       (w_any),
    .o_grant_oh  (w_grant_oh),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  assign w_is_data = (r_cnt[w_grant_idx] < CW'(LEN_SEQ));
  assign w_rd      = w_any && w_is_data;

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    w_fin_nxt   = w_fin;
    if (w_any && (r_cnt[w_grant_idx] == CW'(TOTAL - 1))) w_fin_nxt = w_fin | w_grant_oh;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_clear     = 1'b1;
        end
      end
      ST_RUN: begin
        o_busy = 1'b1;
        if (&w_fin_nxt) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_busy      = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done = 1'b1;
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_pend_vld  <= 1'b0;
      r_pend_term <= 1'b0;
      r_pend_idx  <= '0;
      for (int i = 0; i < LEAF_CNT; i++) r_cnt[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_vld  <= w_any;
      r_pend_idx  <= w_grant_idx;
      r_pend_term <= !w_is_data;
      for (int i = 0; i < LEAF_CNT; i++) begin
        if (w_clear) r_cnt[i] <= '0;
        else if (w_any && (w_grant_idx == IW'(i))) r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end

  // Issue stage drives the read; the write stage lands one cycle later with the read data.
  always_comb begin
    bus.o_mem_rd     = w_rd;
    bus.o_mem_addr   = '0;
    if (w_rd) bus.o_mem_addr = (ADDR_WIDTH'(w_grant_idx) << SH) + ADDR_WIDTH'(r_cnt[w_grant_idx]);
    bus.o_fifo_write = '0;
    w_item           = '0;
    if (r_pend_vld) begin
      bus.o_fifo_write[r_pend_idx] = 1'b1;
      if (!r_pend_term) w_item = bus.i_mem_data;
    end
    bus.o_fifo_item  = w_item;
  end

endmodule
